// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU; optional divide-by-zero guard under ALU_ARBITER_DIV_GUARD_EN.
// Latency: rsp_valid rises 2 cycles after the accepting reqN_ready cycle; peak one operation per 3 cycles.
// Backpressure: the response is held stable until rsp_ready; no new request is accepted until the response drains.
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [3:0]       req0_cmd,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_cmd,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic [3:0]       alu_command,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic             alu_oe,
  input  logic [15:0]      alu_dout,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic             r_gnt_id;
  logic [3:0]       r_cmd;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [15:0]      r_rsp_data;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_op_count;
  logic             w_any;
  logic             w_sel;
  logic             w_accept;
  logic             w_div_guard;

`ifdef ALU_ARBITER_DIV_GUARD_EN
  // Divide with a zero divisor never reaches the ALU; the result is forced instead.
  assign w_div_guard = (r_cmd == 4'b0101) && (r_b == 8'd0);
`else
  assign w_div_guard = 1'b0;
`endif

  // Round-robin pick: a lone requester wins, under contention the one not granted last wins.
  always_comb begin
    w_any = req0_valid | req1_valid;
    w_sel = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  end

  // Next-state and accept decode; no grant while reset is asserted so nothing is lost.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any && !rst) begin
          w_accept    = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC:    w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign req0_ready  = w_accept & ~w_sel;
  assign req1_ready  = w_accept & w_sel;
  assign alu_oe      = (r_state == EXEC) & ~w_div_guard;
  assign alu_command = (r_state == EXEC) ? r_cmd : 4'd0;
  assign alu_a       = (r_state == EXEC) ? r_a   : 8'd0;
  assign alu_b       = (r_state == EXEC) ? r_b   : 8'd0;
  assign rsp_valid   = (r_state == RESP);
  assign rsp_data    = r_rsp_data;
  assign rsp_id      = r_gnt_id;
  assign rsp_err     = r_rsp_err;
  assign op_count    = r_op_count;

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand latch on grant, result capture at end of EXEC, completion count on response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_gnt_id     <= 1'b0;
      r_cmd        <= 4'd0;
      r_a          <= 8'd0;
      r_b          <= 8'd0;
      r_rsp_data   <= 16'd0;
      r_rsp_err    <= 1'b0;
      r_op_count   <= '0;
    end else begin
      if (w_accept) begin
        r_gnt_id     <= w_sel;
        r_last_grant <= w_sel;
        r_cmd        <= w_sel ? req1_cmd : req0_cmd;
        r_a          <= w_sel ? req1_a   : req0_a;
        r_b          <= w_sel ? req1_b   : req0_b;
      end
      if (r_state == EXEC) begin
        r_rsp_data <= w_div_guard ? 16'hFFFF : alu_dout;
        r_rsp_err  <= w_div_guard;
      end
      if ((r_state == RESP) && rsp_ready) begin
        r_op_count <= r_op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU stub and a narrow op counter.
// Checks: reset values, arbitration order, latency, hold under backpressure, mid-op reset, counter wrap.
// Inputs are driven at the falling edge and outputs sampled 1ns later.
module tb_alu_arbiter;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [3:0]    req0_cmd, req1_cmd;
  logic [7:0]    req0_a, req0_b, req1_a, req1_b;
  logic          req0_ready, req1_ready;
  logic          rsp_valid, rsp_ready;
  logic [15:0]   rsp_data;
  logic          rsp_id, rsp_err;
  logic [3:0]    alu_command;
  logic [7:0]    alu_a, alu_b;
  logic          alu_oe;
  logic [15:0]   alu_dout;
  logic [CW-1:0] op_count;

  int n_chk  = 0;
  int n_fail = 0;
  int n_ops  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .alu_command(alu_command), .alu_a(alu_a), .alu_b(alu_b), .alu_oe(alu_oe), .alu_dout(alu_dout),
    .op_count(op_count)
  );

  // ALU stub: 0 add, 1 sub, 2 absolute difference, 4 multiply, 5 divide (0BAD on zero divisor), else xor.
  always_comb begin
    alu_dout = 16'd0;
    case (alu_command)
      4'b0000: alu_dout = {8'd0, alu_a} + {8'd0, alu_b};
      4'b0001: alu_dout = {8'd0, alu_a} - {8'd0, alu_b};
      4'b0010: alu_dout = (alu_a > alu_b) ? {8'd0, alu_a - alu_b} : {8'd0, alu_b - alu_a};
      4'b0100: alu_dout = {8'd0, alu_a} * {8'd0, alu_b};
      4'b0101: alu_dout = (alu_b == 8'd0) ? 16'h0BAD : {8'd0, alu_a / alu_b};
      default: alu_dout = {8'd0, alu_a ^ alu_b};
    endcase
  end

  typedef struct {
    logic        v0;
    logic [3:0]  c0;
    logic [7:0]  a0, b0;
    logic        v1;
    logic [3:0]  c1;
    logic [7:0]  a1, b1;
    logic        id;
    logic [15:0] data;
    logic        oe;
    logic        err;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req0_valid = v.v0; req0_cmd = v.c0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_cmd = v.c1; req1_a = v.a1; req1_b = v.b1;
  endtask

  // One full transaction: accept, EXEC, RESP with immediate rsp_ready, then an idle cycle with valids dropped.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v);
    rsp_ready = 1'b1;
    #1;
    chk("accept_ready0", req0_ready, v.id == 1'b0);
    chk("accept_ready1", req1_ready, v.id == 1'b1);
    chk("accept_rsp_valid", rsp_valid, 0);
    @(negedge clk); #1;
    chk("exec_alu_oe", alu_oe, v.oe);
    if (v.oe) begin
      chk("exec_alu_cmd", alu_command, v.id ? v.c1 : v.c0);
      chk("exec_alu_a", alu_a, v.id ? v.a1 : v.a0);
      chk("exec_alu_b", alu_b, v.id ? v.b1 : v.b0);
    end
    chk("exec_no_ready", {req0_ready, req1_ready}, 0);
    chk("exec_rsp_valid", rsp_valid, 0);
    @(negedge clk); #1;
    chk("resp_valid", rsp_valid, 1);
    chk("resp_data", rsp_data, v.data);
    chk("resp_id", rsp_id, v.id);
    chk("resp_err", rsp_err, v.err);
    chk("resp_no_ready", {req0_ready, req1_ready}, 0);
    n_ops++;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("done_op_count", op_count, n_ops % 16);
    chk("done_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    logic div_en;
`ifdef ALU_ARBITER_DIV_GUARD_EN
    div_en = 1'b1;
`else
    div_en = 1'b0;
`endif
    //           v0  c0       a0     b0     v1  c1       a1      b1     id    data                           oe       err
    tbl[0] = '{1'b1, 4'b0100, 8'd12, 8'd10, 1'b1, 4'b0010, 8'd5,   8'd9,  1'b0, 16'd120,                      1'b1,    1'b0};
    tbl[1] = '{1'b1, 4'b0100, 8'd12, 8'd10, 1'b1, 4'b0010, 8'd5,   8'd9,  1'b1, 16'd4,                        1'b1,    1'b0};
    tbl[2] = '{1'b1, 4'b0100, 8'd12, 8'd10, 1'b1, 4'b0010, 8'd5,   8'd9,  1'b0, 16'd120,                      1'b1,    1'b0};
    tbl[3] = '{1'b1, 4'b0100, 8'd12, 8'd10, 1'b1, 4'b0010, 8'd5,   8'd9,  1'b1, 16'd4,                        1'b1,    1'b0};
    tbl[4] = '{1'b1, 4'b0000, 8'd3,  8'd4,  1'b0, 4'b0000, 8'd0,   8'd0,  1'b0, 16'd7,                        1'b1,    1'b0};
    tbl[5] = '{1'b0, 4'b0000, 8'd0,  8'd0,  1'b1, 4'b0000, 8'd255, 8'd255,1'b1, 16'h01FE,                     1'b1,    1'b0};
    tbl[6] = '{1'b1, 4'b0001, 8'd3,  8'd5,  1'b0, 4'b0000, 8'd0,   8'd0,  1'b0, 16'hFFFE,                     1'b1,    1'b0};
    tbl[7] = '{1'b1, 4'b0101, 8'd9,  8'd3,  1'b0, 4'b0000, 8'd0,   8'd0,  1'b0, 16'd3,                        1'b1,    1'b0};
    tbl[8] = '{1'b0, 4'b0000, 8'd0,  8'd0,  1'b1, 4'b0101, 8'd9,   8'd0,  1'b1, div_en ? 16'hFFFF : 16'h0BAD, ~div_en, div_en};

    // Reset with a valid request present: nothing may be granted.
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_cmd = 4'b0000; req0_a = 8'd1; req0_b = 8'd1;
    req1_valid = 1'b0; req1_cmd = 4'b0000; req1_a = 8'd0; req1_b = 8'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_alu_oe", alu_oe, 0);
    chk("rst_alu_bus", {alu_command, alu_a, alu_b}, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Backpressure: result held five cycles with both requesters waiting.
    @(negedge clk);
    req0_valid = 1'b1; req0_cmd = 4'b0000; req0_a = 8'd20; req0_b = 8'd22;
    req1_valid = 1'b1; req1_cmd = 4'b0001; req1_a = 8'd1;  req1_b = 8'd1;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant0", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_data", rsp_data, 16'd42);
      chk("bp_hold_id", rsp_id, 0);
      chk("bp_no_ready", {req0_ready, req1_ready}, 0);
      chk("bp_count", op_count, n_ops % 16);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp_still_valid", rsp_valid, 1);
    n_ops++;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("bp_count_after", op_count, n_ops % 16);

    // Reset while in EXEC: operation discarded, arbitration history restored.
    @(negedge clk);
    req0_valid = 1'b1; req0_cmd = 4'b0000; req0_a = 8'd1; req0_b = 8'd2;
    #1;
    chk("mid_accept", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_exec_oe", alu_oe, 1);
    @(negedge clk); #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_alu_oe", alu_oe, 0);
    chk("mid_rst_op_count", op_count, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    rst = 1'b0;
    n_ops = 0;
    run_vec(tbl[0]);

    // Fill up to 16 completions so the 4-bit counter wraps.
    for (int k = 0; k < 20 && n_ops < 16; k++) run_vec(tbl[4]);
    chk("wrap_ops_done", n_ops, 16);
    chk("wrap_op_count", op_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
